// File: rtl/systolic_tile_feeder_if.sv
// Row-in / vector-out bus between the tile memory reader, the feeder and the skew block.
interface systolic_tile_feeder_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 5
);
  logic                          In_Valid;
  logic                          In_Ready;
  logic [LENGTH-1:0][WIDTH-1:0]  In_Row;
  logic                          Out_Stall;
  logic [LENGTH-1:0][WIDTH-1:0]  Out_Vector;
  logic                          Out_EN;
  logic                          Out_Valid;
  logic                          Tile_Done;
  logic                          Busy;

  modport master (
    output In_Valid, In_Row, Out_Stall,
    input  In_Ready, Out_Vector, Out_EN, Out_Valid, Tile_Done, Busy
  );

  modport slave (
    input  In_Valid, In_Row, Out_Stall,
    output In_Ready, Out_Vector, Out_EN, Out_Valid, Tile_Done, Busy
  );
endinterface

// File: rtl/systolic_tile_feeder.sv
// Buffers a LENGTH x LENGTH tile and streams it row-per-cycle into the skew block, then flushes.
// Define FEEDER_DOUBLE_BUFFER_EN for ping-pong banks that load while the other bank streams.
module systolic_tile_feeder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 5
) (
  input logic                  CLK,
  input logic                  SYNC_RST,
  systolic_tile_feeder_if.slave io
);
  localparam int unsigned CW = $clog2(LENGTH) + 1;
  localparam int unsigned IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] ROW_LAST   = CW'(LENGTH - 1);
  // Unreachable when LENGTH==1 (no flush phase), so the wrap is harmless.
  localparam logic [CW-1:0] FLUSH_LAST = CW'(LENGTH - 2);

  typedef logic [LENGTH-1:0][WIDTH-1:0] row_t;
  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [CW-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_load_last;
  logic          w_tile_end;
  row_t          w_rd_row;
  row_t          w_out_vector;
  logic          w_out_en;
  logic          w_out_valid;
  logic          w_tile_done;

`ifdef FEEDER_DOUBLE_BUFFER_EN
  // r_bank is the streaming bank; the load bank is always the other one.
  row_t r_buf [2][LENGTH];
  logic r_bank, w_bank_nxt;
  logic r_ld_full, w_ld_full_nxt;

  assign w_in_ready = ~r_ld_full;
  assign w_rd_row   = r_buf[r_bank][IW'(r_rd_cnt)];

  always_ff @(posedge CLK) begin
    if (SYNC_RST && w_accept) r_buf[~r_bank][IW'(r_wr_cnt)] <= io.In_Row;
  end
`else
  row_t r_buf [LENGTH];

  assign w_in_ready = (r_state == S_LOAD);
  assign w_rd_row   = r_buf[IW'(r_rd_cnt)];

  always_ff @(posedge CLK) begin
    if (SYNC_RST && w_accept) r_buf[IW'(r_wr_cnt)] <= io.In_Row;
  end
`endif

  assign w_accept    = io.In_Valid & w_in_ready;
  assign w_load_last = w_accept && (r_wr_cnt == ROW_LAST);

  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      r_state   <= S_LOAD;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
`ifdef FEEDER_DOUBLE_BUFFER_EN
      r_bank    <= 1'b0;
      r_ld_full <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
`ifdef FEEDER_DOUBLE_BUFFER_EN
      r_bank    <= w_bank_nxt;
      r_ld_full <= w_ld_full_nxt;
`endif
    end
  end

  // Next state, counters and output decode; outputs depend on registers and Out_Stall only.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    w_tile_end   = 1'b0;
    w_out_vector = '0;
    w_out_en     = 1'b0;
    w_out_valid  = 1'b0;
    w_tile_done  = 1'b0;
`ifdef FEEDER_DOUBLE_BUFFER_EN
    w_bank_nxt    = r_bank;
    w_ld_full_nxt = r_ld_full;
`endif

    if (w_accept) w_wr_cnt_nxt = w_load_last ? '0 : r_wr_cnt + CW'(1);

    case (r_state)
      S_LOAD: begin
        if (w_load_last) begin
          w_state_nxt  = S_STREAM;
          w_rd_cnt_nxt = '0;
`ifdef FEEDER_DOUBLE_BUFFER_EN
          w_bank_nxt   = ~r_bank;
`endif
        end
      end
      S_STREAM: begin
        w_out_vector = w_rd_row;
        w_out_valid  = 1'b1;
        w_out_en     = ~io.Out_Stall;
        if (!io.Out_Stall) begin
          if (r_rd_cnt == ROW_LAST) begin
            w_rd_cnt_nxt = '0;
            if (LENGTH == 1) w_tile_end  = 1'b1;
            else             w_state_nxt = S_FLUSH;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        w_out_en = ~io.Out_Stall;
        if (!io.Out_Stall) begin
          if (r_rd_cnt == FLUSH_LAST) begin
            w_rd_cnt_nxt = '0;
            w_tile_end   = 1'b1;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase

`ifdef FEEDER_DOUBLE_BUFFER_EN
    if (w_load_last && (r_state != S_LOAD)) w_ld_full_nxt = 1'b1;
`endif

    if (w_tile_end) begin
      w_tile_done = 1'b1;
`ifdef FEEDER_DOUBLE_BUFFER_EN
      // A bank that fills on this very edge counts as already full.
      if (r_ld_full || w_load_last) begin
        w_state_nxt   = S_STREAM;
        w_bank_nxt    = ~r_bank;
        w_ld_full_nxt = 1'b0;
      end else begin
        w_state_nxt   = S_LOAD;
      end
`else
      w_state_nxt = S_LOAD;
`endif
    end
  end

  assign io.In_Ready   = w_in_ready;
  assign io.Out_Vector = w_out_vector;
  assign io.Out_EN     = w_out_en;
  assign io.Out_Valid  = w_out_valid;
  assign io.Tile_Done  = w_tile_done;
  assign io.Busy       = (r_state == S_STREAM) || (r_state == S_FLUSH);

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Directed and randomized checks of systolic_tile_feeder against a beat-queue reference model.
`timescale 1ns/1ps
module tb_systolic_tile_feeder;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LENGTH = 5;
  localparam int unsigned VW     = WIDTH * LENGTH;

  typedef logic [LENGTH-1:0][WIDTH-1:0] row_t;
  typedef struct { row_t vec; logic valid; logic done; } beat_t;

  logic CLK = 1'b0;
  logic SYNC_RST;

  systolic_tile_feeder_if #(.WIDTH(WIDTH), .LENGTH(LENGTH)) io ();

  systolic_tile_feeder #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .CLK      (CLK),
    .SYNC_RST (SYNC_RST),
    .io       (io)
  );

  always #5 CLK = ~CLK;

  // Reference: each complete tile becomes 2*LENGTH-1 expected output beats.
  beat_t exp_q[$];
  row_t  part_q[$];
  logic  exp_ready;
  int    errors = 0;
  int    checks = 0;
  string phase  = "init";
  logic  o_busy, o_done, o_valid, o_ready;
  row_t  o_vec;

  function automatic row_t mk_row(input int r);
    row_t x;
    for (int i = 0; i < int'(LENGTH); i++) x[i] = 8'(10 * r + i);
    return x;
  endfunction

  function automatic int tiles_pending();
    int n = 0;
    foreach (exp_q[k]) if (exp_q[k].done) n++;
    return n;
  endfunction

  function automatic logic model_ready();
`ifdef FEEDER_DOUBLE_BUFFER_EN
    return tiles_pending() < 2;
`else
    return tiles_pending() == 0;
`endif
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %b expected %b", phase, tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input row_t obs, input row_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    beat_t b;
    logic  have;
    have = (exp_q.size() != 0);
    if (have) b = exp_q[0];
    else begin b.vec = '0; b.valid = 1'b0; b.done = 1'b0; end
    chk1("in_ready",   io.In_Ready,  exp_ready);
    chk1("busy",       io.Busy,      have);
    chk1("out_en",     io.Out_EN,    have & ~io.Out_Stall);
    chk1("out_valid",  io.Out_Valid, b.valid);
    chk1("tile_done",  io.Tile_Done, b.done & ~io.Out_Stall);
    chkv("out_vector", io.Out_Vector, b.vec);
  endtask

  task automatic model_edge();
    logic acc;
    if (!SYNC_RST) begin
      exp_q.delete();
      part_q.delete();
      return;
    end
    acc = io.In_Valid & exp_ready;
    if (exp_q.size() != 0 && !io.Out_Stall) void'(exp_q.pop_front());
    if (acc) begin
      part_q.push_back(io.In_Row);
      if (part_q.size() == LENGTH) begin
        for (int r = 0; r < int'(LENGTH); r++)
          exp_q.push_back('{vec: part_q[r], valid: 1'b1, done: (LENGTH == 1)});
        for (int k = 0; k < int'(LENGTH) - 1; k++)
          exp_q.push_back('{vec: '0, valid: 1'b0, done: (k == int'(LENGTH) - 2)});
        part_q.delete();
      end
    end
  endtask

  // One clock: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic v, input row_t row, input logic stall, input logic rst_n,
                       input bit do_chk, output logic acc);
    @(negedge CLK);
    SYNC_RST     = rst_n;
    io.In_Valid  = v;
    io.In_Row    = row;
    io.Out_Stall = stall;
    #1;
    exp_ready = model_ready();
    acc       = v & exp_ready & rst_n;
    o_busy    = io.Busy;
    o_done    = io.Tile_Done;
    o_valid   = io.Out_Valid;
    o_ready   = io.In_Ready;
    o_vec     = io.Out_Vector;
    if (do_chk) check_outputs();
    @(posedge CLK);
    model_edge();
  endtask

  task automatic load_tile(input int base, input bit alt, output int busy_ready);
    int   n = 0;
    logic acc;
    busy_ready = 0;
    for (int k = 0; k < 200 && n < int'(LENGTH); k++) begin
      cycle(alt ? logic'(k % 2 == 0) : 1'b1, mk_row(base + n), 1'b0, 1'b1, 1'b1, acc);
      if (o_busy && o_ready) busy_ready++;
      if (acc) n++;
    end
    chk_int("load_accepts", n, int'(LENGTH));
  endtask

  task automatic drain(input int stall_from, input int stall_len,
                       output int busy_cnt, output int done_at);
    logic acc;
    busy_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, '0, logic'(k >= stall_from && k < stall_from + stall_len), 1'b1, 1'b1, acc);
      if (o_busy) busy_cnt++;
      if (o_done) done_at = k + 1;
      if (!o_busy) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic      acc;
    int        bc, da, br, done_cyc, b0_cyc;
    logic [63:0] rnd;

    SYNC_RST     = 1'b0;
    io.In_Valid  = 1'b0;
    io.In_Row    = '0;
    io.Out_Stall = 1'b0;

    phase = "t1_reset";
    cycle(1'b1, mk_row(7), 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b1, mk_row(7), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    chk1("ready_after_reset", o_ready, 1'b1);
    chkv("vec_after_reset", o_vec, '0);

    phase = "t2_basic";
    load_tile(0, 1'b0, br);
    drain(100, 0, bc, da);
    chk_int("tile_cycles", bc, 2 * int'(LENGTH) - 1);
    chk_int("done_cycle", da, 2 * int'(LENGTH) - 1);
    chk1("ready_after_tile", o_ready, 1'b1);

    phase = "t3_stall";
    load_tile(0, 1'b0, br);
    drain(2, 2, bc, da);
    chk_int("tile_cycles", bc, 2 * int'(LENGTH) + 1);
    chk_int("done_cycle", da, 2 * int'(LENGTH) + 1);

    phase = "t4_alternate";
    load_tile(0, 1'b1, br);
    drain(100, 0, bc, da);
    chk_int("tile_cycles", bc, 2 * int'(LENGTH) - 1);

    phase = "t5_midreset";
    load_tile(0, 1'b0, br);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    chkv("row2_shown", o_vec, mk_row(2));
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    chk1("busy_after", o_busy, 1'b0);
    chk1("ready_after", o_ready, 1'b1);
    load_tile(0, 1'b0, br);
    drain(100, 0, bc, da);
    chk_int("fresh_tile_cycles", bc, 2 * int'(LENGTH) - 1);

    phase = "t6_overlap";
    load_tile(0, 1'b0, br);
    load_tile(50, 1'b0, br);
`ifdef FEEDER_DOUBLE_BUFFER_EN
    done_cyc = -1;
    b0_cyc   = -1;
    for (int k = 0; k < 100 && b0_cyc < 0; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
      if (o_done && done_cyc < 0) done_cyc = k;
      if (o_valid && o_vec == mk_row(50)) b0_cyc = k;
    end
    chk_int("b_row0_gap", b0_cyc - done_cyc, 1);
`else
    done_cyc = 0;
    b0_cyc   = 0;
    chk_int("ready_while_busy", br, 0);
`endif
    drain(100, 0, bc, da);
    chk1("idle_after_overlap", o_busy, 1'b0);

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      rnd = {$urandom(), $urandom()};
      cycle(logic'($urandom_range(0, 9) < 6), rnd[VW-1:0],
            logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 149) != 0), 1'b1, acc);
    end
    drain(100, 0, bc, da);
    chk1("idle_at_end", o_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
